// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/subtract arbiter: op encoding, default
// operand width and a constant-evaluable log2 helper for index widths.
package addsub_arbiter_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int DEFAULT_DATA_W = 16;

  // Smallest r such that 2**r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and walks
// upward with wrap-around; the first active request wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               grant_valid_o
);

  // Priority search from the pointer; only the first hit is granted.
  always_comb begin
    int idx;
    idx           = 0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one registered add/subtract unit among NUM_REQ requesters using
// round-robin arbitration. One result register feeds a single valid/ready
// response port tagged with the owning requester index.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until that edge;
// ready never waits on valid of the same index except through arbitration.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W:0]            rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic [15:0]                ops_cnt
);

  if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
    $error("addsub_arbiter: ID_W must equal clog2(NUM_REQ)");
  end

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]        ops_cnt_q, ops_cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic               can_accept;
  logic               accept;
  logic               rsp_fire;
  logic [DATA_W-1:0]  op_a, op_b;
  logic               op_sel;
  logic [DATA_W:0]    result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i         (req_valid),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // Operand select, arithmetic and handshake qualifiers for the winner.
  always_comb begin
    can_accept = !rsp_valid_q || rsp_ready;
    accept     = grant_valid && can_accept;
    rsp_fire   = rsp_valid_q && rsp_ready;
    req_ready  = can_accept ? grant : '0;
    op_a       = req_a[grant_idx*DATA_W +: DATA_W];
    op_b       = req_b[grant_idx*DATA_W +: DATA_W];
    op_sel     = req_op[grant_idx];
    // Bit DATA_W is the carry for add and the borrow flag for subtract.
    result     = (op_sel == OP_ADD) ? ({1'b0, op_a} + {1'b0, op_b})
                                    : ({1'b0, op_a} - {1'b0, op_b});
  end

  // Next state: a new accept reloads the output register (no bubble even
  // while draining); a drain without accept only clears valid so data/id
  // stay frozen.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ops_cnt_d   = ops_cnt_q;
    if (rsp_fire) begin
      ops_cnt_d   = ops_cnt_q + 16'd1;
      rsp_valid_d = 1'b0;
    end
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = result;
      rsp_id_d    = grant_idx;
      ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ops_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed steps plus a randomized phase, checked
// every cycle against a transaction-level reference model.
module tb_addsub_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_op;
  logic [N*DW-1:0]   req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [DW:0]       rsp_data;
  logic [IW-1:0]     rsp_id;
  logic [15:0]       ops_cnt;

  always #5 clk = ~clk;

  addsub_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .ops_cnt   (ops_cnt)
  );

  // ---------------- requester state ----------------
  bit           pend [N];
  logic [DW-1:0] ra  [N];
  logic [DW-1:0] rb  [N];
  bit           rop [N];
  int           density;
  bit           refill;
  bit           rand_rdy;

  // ---------------- reference model ----------------
  int           m_ptr;
  bit           m_rv;
  logic [DW:0]  m_data;
  int           m_id;
  logic [15:0]  m_cnt;
  logic [IW+DW:0] exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [DW:0] ref_result(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input bit op);
    int r;
    if (op) r = int'(a) + int'(b);
    else    r = int'(a) - int'(b) + (1 << (DW + 1));
    r = r % (1 << (DW + 1));
    return (DW+1)'(r);
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_rv   = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_a[i*DW +: DW]    = ra[i];
      req_b[i*DW +: DW]    = rb[i];
      req_op[i]            = rop[i];
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit op);
    pend[i] = 1'b1;
    ra[i]   = a;
    rb[i]   = b;
    rop[i]  = op;
  endtask

  task automatic new_req(input int i);
    set_req(i, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // One clock: check everything at the negedge, advance the model, then
  // apply the next inputs just after the rising edge.
  task automatic cycle();
    int            w;
    bit            can;
    logic [N-1:0]  exp_rdy;
    logic [DW:0]   res;
    logic [IW+DW:0] e;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    can     = !m_rv || rsp_ready;
    exp_rdy = '0;
    if (w >= 0 && can) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("ops_cnt",   32'(ops_cnt),   32'(m_cnt));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_scoreboard", 32'({rsp_id, rsp_data}), 32'(e));
      end
    end
    if (m_rv && rsp_ready) m_cnt = m_cnt + 16'd1;
    if (w >= 0 && can) begin
      res    = ref_result(ra[w], rb[w], rop[w]);
      m_rv   = 1'b1;
      m_data = res;
      m_id   = w;
      m_ptr  = (w + 1) % N;
      exp_q.push_back({IW'(w), res});
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        pend[i] = 1'b0;
        if (refill) new_req(i);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < density) new_req(i);
    end
    if (rand_rdy) rsp_ready = ($urandom_range(0, 99) >= 30);
    drive();
  endtask

  // Requester hold rule: a valid left unaccepted must stay with same operands.
  logic [N-1:0]    hold_v;
  logic [N*DW-1:0] hold_a, hold_b;
  logic [N-1:0]    hold_op;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hold_v[i]) begin
          assert (req_valid[i] && req_a[i*DW +: DW] === hold_a[i*DW +: DW] &&
                  req_b[i*DW +: DW] === hold_b[i*DW +: DW] && req_op[i] === hold_op[i])
          else begin
            miscompares++;
            $error("FAIL hold_rule req=%0d valid=%0b expected held request", i, req_valid[i]);
          end
        end
      end
      hold_v  = req_valid & ~req_ready;
      hold_a  = req_a;
      hold_b  = req_b;
      hold_op = req_op;
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    density   = 0;
    refill    = 1'b0;
    rand_rdy  = 1'b0;
    hold_v    = '0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle
    repeat (10) cycle();

    // Single add with carry out
    set_req(2, 16'hFFFF, 16'h0001, 1'b1);
    drive();
    cycle();
    chk("add_carry_data", 32'(rsp_data), 32'h10000);
    chk("add_carry_id",   32'(rsp_id),   32'd2);
    repeat (2) cycle();
    chk("add_ops_cnt", 32'(ops_cnt), 32'd1);

    // Subtract with and without borrow
    set_req(0, 16'd3, 16'd5, 1'b0);
    drive();
    cycle();
    chk("sub_borrow_data", 32'(rsp_data), 32'h1FFFE);
    chk("sub_borrow_id",   32'(rsp_id),   32'd0);
    set_req(0, 16'd5, 16'd3, 1'b0);
    drive();
    cycle();
    chk("sub_plain_data", 32'(rsp_data), 32'h00002);
    repeat (2) cycle();

    // Round-robin with all requesters continuously valid
    refill = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, DW'(16'h1000 * (i + 1)), DW'(i + 7), 1'(i % 2));
    drive();
    repeat (10) cycle();
    refill = 1'b0;
    repeat (6) cycle();

    // Backpressure while several requesters wait
    set_req(1, 16'h1234, 16'h0101, 1'b1);
    set_req(2, 16'h0001, 16'h0002, 1'b0);
    set_req(3, 16'h8000, 16'h8000, 1'b1);
    drive();
    cycle();
    rsp_ready = 1'b0;
    repeat (5) cycle();
    rsp_ready = 1'b1;
    repeat (5) cycle();

    // Randomized traffic with random backpressure
    density  = 40;
    rand_rdy = 1'b1;
    repeat (400) cycle();
    density   = 0;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) cycle();

    // Reset mid-operation: accept from 2 leaves pointer at 3 without reset
    set_req(2, 16'h00AA, 16'h0055, 1'b1);
    drive();
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_cnt",   32'(ops_cnt),   32'd0);
    chk("rst_async_data",  32'(rsp_data),  32'd0);
    model_reset();
    set_req(1, 16'h0010, 16'h0001, 1'b0);
    set_req(3, 16'h0020, 16'h0002, 1'b1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("post_rst_grant_id",   32'(rsp_id),   32'd1);
    chk("post_rst_grant_data", 32'(rsp_data), 32'h0000F);
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
